// File: rtl/router_pkt_tx_if.sv
// Host and router side signals of the router packet transmitter.
// master: traffic engine / router model. slave: router_pkt_tx.
interface router_pkt_tx_if;
    logic       start;
    logic [1:0] addr_in;
    logic [5:0] len_in;
    logic [7:0] pl_data;
    logic       pl_valid;
    logic       pl_ready;
    logic       busy;
    logic       corrupt_parity;
    logic       pkt_valid;
    logic [7:0] data_out;
    logic       tx_active;
    logic       done;
    logic       err;

    modport master (
        output start, addr_in, len_in, pl_data, pl_valid, busy, corrupt_parity,
        input  pl_ready, pkt_valid, data_out, tx_active, done, err
    );

    modport slave (
        input  start, addr_in, len_in, pl_data, pl_valid, busy, corrupt_parity,
        output pl_ready, pkt_valid, data_out, tx_active, done, err
    );
endinterface

// File: rtl/router_pkt_tx.sv
// Router packet transmitter: buffers a payload, then sends
// header {len,addr}, len payload bytes (pkt_valid=1) and a parity byte
// (pkt_valid=0), stalling on router busy. Every output is a flop.
// Optional: ROUTER_TX_PARITY_CORRUPT_EN inverts the parity byte when
// corrupt_parity was high on the accepted start.
module router_pkt_tx #(
    parameter int MAX_LEN    = 63,
    parameter int GAP_CYCLES = 1
) (
    input logic            clock,
    input logic            resetn,
    router_pkt_tx_if.slave bus
);
    typedef enum logic [2:0] {IDLE, LOAD, HEADER, PAYLOAD, PARITY, GAP} state_t;

    localparam logic [5:0] LEN_MAX  = 6'(MAX_LEN);
    localparam logic [7:0] GAP_LAST = 8'(GAP_CYCLES - 1);

    state_t     state, state_nxt;
    logic [1:0] addr_r;
    logic [5:0] len_r;
    logic [5:0] idx;
    logic [7:0] parity;
    logic [7:0] gap_cnt;
    logic [7:0] parity_tx;
    logic [7:0] buf_mem [MAX_LEN];

    logic       bad_req, start_ok, advance, load_last, pay_last;

    logic       pkt_valid_q, pl_ready_q, tx_active_q, done_q, err_q;
    logic [7:0] data_out_q;
    logic       pkt_valid_nxt, pl_ready_nxt, tx_active_nxt, done_nxt, err_nxt;
    logic [7:0] data_out_nxt;

    assign bad_req   = (bus.addr_in == 2'd3) || (bus.len_in == 6'd0) || (bus.len_in > LEN_MAX);
    assign start_ok  = bus.start && !bad_req;
    assign advance   = !bus.busy;
    assign pay_last  = (idx == len_r - 6'd1);
    assign load_last = bus.pl_valid && pay_last;

`ifdef ROUTER_TX_PARITY_CORRUPT_EN
    logic corrupt_r;

    // Remember the corruption request of the packet being sent
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn)                         corrupt_r <= 1'b0;
        else if (state == IDLE && start_ok) corrupt_r <= bus.corrupt_parity;
    end

    assign parity_tx = corrupt_r ? ~parity : parity;
`else
    logic unused_corrupt;
    assign unused_corrupt = bus.corrupt_parity;
    assign parity_tx      = parity;
`endif

    // State and registered outputs
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state       <= IDLE;
            pkt_valid_q <= 1'b0;
            data_out_q  <= 8'h00;
            pl_ready_q  <= 1'b0;
            tx_active_q <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state       <= state_nxt;
            pkt_valid_q <= pkt_valid_nxt;
            data_out_q  <= data_out_nxt;
            pl_ready_q  <= pl_ready_nxt;
            tx_active_q <= tx_active_nxt;
            done_q      <= done_nxt;
            err_q       <= err_nxt;
        end
    end

    // Next-state: load until len bytes taken, then walk the bytes on !busy
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start_ok)              state_nxt = LOAD;
            LOAD:    if (load_last)             state_nxt = HEADER;
            HEADER:  if (advance)               state_nxt = PAYLOAD;
            PAYLOAD: if (advance && pay_last)   state_nxt = PARITY;
            PARITY:  if (advance)               state_nxt = GAP;
            GAP:     if (gap_cnt == GAP_LAST)   state_nxt = IDLE;
            default:                            state_nxt = IDLE;
        endcase
    end

    // Output next-values; data_out holds unless a new byte is presented
    always_comb begin
        pkt_valid_nxt = (state_nxt == HEADER) || (state_nxt == PAYLOAD);
        pl_ready_nxt  = (state_nxt == LOAD);
        tx_active_nxt = (state_nxt != IDLE);
        done_nxt      = (state == PARITY) && advance;
        err_nxt       = (state == IDLE) && bus.start && bad_req;
        data_out_nxt  = data_out_q;
        case (state)
            LOAD:    if (load_last) data_out_nxt = {len_r, addr_r};
            HEADER:  if (advance)   data_out_nxt = buf_mem[0];
            PAYLOAD: if (advance)   data_out_nxt = pay_last ? parity_tx : buf_mem[idx + 6'd1];
            PARITY:  if (advance)   data_out_nxt = 8'h00;
            default: ;
        endcase
    end

    // Packet fields, running parity, byte index and gap counter
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            addr_r  <= 2'd0;
            len_r   <= 6'd0;
            parity  <= 8'h00;
            idx     <= 6'd0;
            gap_cnt <= 8'd0;
        end else begin
            case (state)
                IDLE: if (start_ok) begin
                    addr_r <= bus.addr_in;
                    len_r  <= bus.len_in;
                    parity <= {bus.len_in, bus.addr_in};
                    idx    <= 6'd0;
                end
                LOAD: if (bus.pl_valid) begin
                    parity <= parity ^ bus.pl_data;
                    idx    <= pay_last ? 6'd0 : idx + 6'd1;
                end
                HEADER:  if (advance) idx <= 6'd0;
                PAYLOAD: if (advance && !pay_last) idx <= idx + 6'd1;
                PARITY:  gap_cnt <= 8'd0;
                GAP:     gap_cnt <= gap_cnt + 8'd1;
                default: ;
            endcase
        end
    end

    // Payload buffer; contents need no reset
    always_ff @(posedge clock) begin
        if (state == LOAD && bus.pl_valid) buf_mem[idx] <= bus.pl_data;
    end

    assign bus.pkt_valid = pkt_valid_q;
    assign bus.data_out  = data_out_q;
    assign bus.pl_ready  = pl_ready_q;
    assign bus.tx_active = tx_active_q;
    assign bus.done      = done_q;
    assign bus.err       = err_q;
endmodule

// File: tb/tb_router_pkt_tx.sv
// Bench for router_pkt_tx: a queue model of the expected wire stream is
// checked against the DUT every cycle, plus literal checks of known packets.
module tb_router_pkt_tx;
    localparam int MAX_LEN = 63;
    localparam int GAP     = 1;
`ifdef ROUTER_TX_PARITY_CORRUPT_EN
    localparam bit COR_EN = 1'b1;
`else
    localparam bit COR_EN = 1'b0;
`endif

    logic clock = 1'b0;
    logic resetn = 1'b0;
    router_pkt_tx_if bus();

    router_pkt_tx #(.MAX_LEN(MAX_LEN), .GAP_CYCLES(GAP)) dut (
        .clock (clock),
        .resetn(resetn),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%h exp=%h t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- model: wire stream as a queue of per-cycle entries
    typedef struct packed { logic pv; logic [7:0] d; logic tx; logic first; } ent_t;
    ent_t       q[$];
    logic       m_load = 1'b0, m_err = 1'b0, m_idle, m_bad;
    int         m_cnt = 0, m_len = 0;
    logic [1:0] m_addr;
    logic       m_cor;
    logic [7:0] m_pay [64];
    logic [7:0] m_par, p;

    always @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            q.delete();
            m_load = 1'b0;
            m_err  = 1'b0;
            m_cnt  = 0;
        end else begin
            m_idle = !m_load && (q.size() == 0);
            m_bad  = (bus.addr_in == 2'd3) || (bus.len_in == 0) || (int'(bus.len_in) > MAX_LEN);
            m_err  = m_idle && bus.start && m_bad;
            if (q.size() > 0 && (!q[0].tx || !bus.busy)) void'(q.pop_front());
            if (m_load && bus.pl_valid) begin
                m_pay[m_cnt] = bus.pl_data;
                m_cnt++;
                if (m_cnt == m_len) begin
                    m_load = 1'b0;
                    p = {6'(m_len), m_addr};
                    q.push_back(ent_t'{1'b1, p, 1'b1, 1'b0});
                    for (int i = 0; i < m_len; i++) begin
                        p = p ^ m_pay[i];
                        q.push_back(ent_t'{1'b1, m_pay[i], 1'b1, 1'b0});
                    end
                    m_par = (COR_EN && m_cor) ? ~p : p;
                    q.push_back(ent_t'{1'b0, m_par, 1'b1, 1'b0});
                    for (int g = 0; g < GAP; g++) q.push_back(ent_t'{1'b0, 8'h00, 1'b0, g == 0});
                end
            end
            if (m_idle && bus.start && !m_bad) begin
                m_load = 1'b1;
                m_cnt  = 0;
                m_len  = int'(bus.len_in);
                m_addr = bus.addr_in;
                m_cor  = bus.corrupt_parity;
            end
        end
    end

    // ---------------- per-cycle compare against the model
    logic [12:0] exp_v, act_v;
    always @(negedge clock) begin
        if (q.size() > 0) exp_v = {q[0].pv, q[0].d, m_load, 1'b1, q[0].first, m_err};
        else              exp_v = {1'b0, 8'h00, m_load, m_load, 1'b0, m_err};
        act_v = {bus.pkt_valid, bus.data_out, bus.pl_ready, bus.tx_active, bus.done, bus.err};
        chk("cycle{pv,data,rdy,act,done,err}", 32'(act_v), 32'(exp_v));
    end

    // ---------------- recorder of transmit-phase wire values {pv,data}
    logic [8:0] rec [64];
    int rec_n = 0;
    always @(negedge clock) begin
        if (bus.tx_active && !bus.pl_ready && rec_n < 64) begin
            rec[rec_n] = {bus.pkt_valid, bus.data_out};
            rec_n++;
        end
    end

    logic [7:0] pay [3] = '{8'hA5, 8'h3C, 8'h0F};

    task automatic send_pkt(input logic [1:0] a, input logic [5:0] l, input logic [15:0] vpat,
                            input int npat, input logic cp);
        int k;
        k = 0;
        rec_n = 0;
        @(negedge clock);
        bus.start = 1'b1; bus.addr_in = a; bus.len_in = l; bus.corrupt_parity = cp;
        @(negedge clock);
        bus.start = 1'b0; bus.corrupt_parity = 1'b0;
        for (int i = 0; i < npat; i++) begin
            bus.pl_valid = vpat[i];
            bus.pl_data  = vpat[i] ? pay[k % 3] : 8'h00;
            if (vpat[i]) k++;
            @(negedge clock);
        end
        bus.pl_valid = 1'b0;
        bus.pl_data  = 8'h00;
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while (bus.tx_active && n < 60) begin
            @(negedge clock);
            n++;
        end
        @(negedge clock);
        chk(name, 32'(bus.tx_active), 32'd0);
    endtask

    task automatic chk_basic(input string tag, input logic [7:0] par);
        chk({tag, "_hdr"}, 32'(rec[0]), 32'h10E);
        chk({tag, "_b0"},  32'(rec[1]), 32'h1A5);
        chk({tag, "_b1"},  32'(rec[2]), 32'h13C);
        chk({tag, "_b2"},  32'(rec[3]), 32'h10F);
        chk({tag, "_par"}, 32'(rec[4]), {23'd0, 1'b0, par});
        chk({tag, "_gap"}, 32'(rec[5]), 32'h000);
    endtask

    initial begin
        int n3c;
        logic found;
        bus.start = 0; bus.addr_in = 0; bus.len_in = 0; bus.pl_data = 0;
        bus.pl_valid = 0; bus.busy = 0; bus.corrupt_parity = 0;
        repeat (2) @(negedge clock);
        chk("reset_outputs", 32'(act_v), 32'd0);
        resetn = 1'b1;

        // basic packet, no stalls
        send_pkt(2'd2, 6'd3, 16'b111, 3, 1'b0);
        wait_idle("idle_after_basic");
        chk("model_parity", 32'(m_par), 32'h98);
        chk("rec_len_basic", rec_n, 6);
        chk_basic("basic", 8'h98);

        // busy held for 3 cycles while 3C is on the wire
        send_pkt(2'd2, 6'd3, 16'b111, 3, 1'b0);
        found = 1'b0;
        for (int i = 0; i < 30 && !found; i++) begin
            @(negedge clock);
            if (bus.pkt_valid && bus.data_out == 8'h3C) found = 1'b1;
        end
        chk("saw_3C", 32'(found), 32'd1);
        bus.busy = 1'b1;
        repeat (3) @(negedge clock);
        bus.busy = 1'b0;
        wait_idle("idle_after_busy");
        n3c = 0;
        for (int i = 0; i < rec_n; i++) if (rec[i] == 9'h13C) n3c++;
        chk("busy_3C_cycles", n3c, 4);
        chk("busy_after", 32'(rec[6]), 32'h10F);
        chk("busy_par", 32'(rec[7]), 32'h098);

        // gappy pl_valid 1,0,0,1,0,1
        send_pkt(2'd2, 6'd3, 16'b101001, 6, 1'b0);
        wait_idle("idle_after_gappy");
        chk_basic("gappy", 8'h98);

        // rejected starts
        for (int t = 0; t < 2; t++) begin
            @(negedge clock);
            bus.start = 1'b1;
            bus.addr_in = (t == 0) ? 2'd3 : 2'd1;
            bus.len_in  = (t == 0) ? 6'd3 : 6'd0;
            @(negedge clock);
            bus.start = 1'b0;
            chk("err_pulse", 32'(bus.err), 32'd1);
            chk("err_no_tx", 32'({bus.tx_active, bus.pkt_valid}), 32'd0);
            @(negedge clock);
            chk("err_clears", 32'(bus.err), 32'd0);
        end

        // async reset in the middle of the payload
        send_pkt(2'd2, 6'd3, 16'b111, 3, 1'b0);
        found = 1'b0;
        for (int i = 0; i < 30 && !found; i++) begin
            @(negedge clock);
            if (bus.pkt_valid && bus.data_out == 8'hA5) found = 1'b1;
        end
        chk("saw_A5", 32'(found), 32'd1);
        #2 resetn = 1'b0;
        #1;
        chk("async_reset_now", 32'({bus.pkt_valid, bus.data_out, bus.tx_active}), 32'd0);
        @(negedge clock);
        resetn = 1'b1;
        // clean packet afterwards: addr 1, A5 3C -> 09 A5 3C 90
        send_pkt(2'd1, 6'd2, 16'b11, 2, 1'b0);
        wait_idle("idle_after_reset_pkt");
        chk("post_rst_hdr", 32'(rec[0]), 32'h109);
        chk("post_rst_b1",  32'(rec[2]), 32'h13C);
        chk("post_rst_par", 32'(rec[3]), 32'h090);

        // corrupt request: inverted parity only with the feature built in
        send_pkt(2'd2, 6'd3, 16'b111, 3, 1'b1);
        wait_idle("idle_after_corrupt");
        chk_basic("corrupt", COR_EN ? 8'h67 : 8'h98);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog act=timeout exp=finish");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/router_pkt_tx.md
Name: router_pkt_tx

Overview:
Packet source for the 1x3 router input port, the transmitter end of the protocol the router register block receives. It collects a payload into an internal buffer, then emits the packet in router format: header byte {len[5:0], addr[1:0]}, then len payload bytes with pkt_valid=1, then the parity byte with pkt_valid=0. It honours router busy and sits between a host/traffic engine and the router's pkt_valid/data_in inputs.

Parameters:
- MAX_LEN, 63: payload buffer depth in bytes. Must be ≤ 63.
- GAP_CYCLES, 1: idle cycles after the parity byte before the next packet can start. Must be ≥ 1.

Ports:
- clock  in  1  rising-edge clock
- resetn  in  1  asynchronous active-low reset
- start  in  1  request a packet; sampled only in IDLE
- addr_in  in  2  destination port 0..2; captured on accepted start
- len_in  in  6  payload length 1..MAX_LEN; captured on accepted start
- pl_data  in  8  payload byte
- pl_valid  in  1  pl_data valid
- pl_ready  out  1  block accepts payload (high only in LOAD)
- busy  in  1  router busy; stalls the transmit byte
- corrupt_parity  in  1  see Optional Feature
- pkt_valid  out  1  to router pkt_valid
- data_out  out  8  to router data_in
- tx_active  out  1  high from accepted start until return to IDLE
- done  out  1  1-cycle pulse on the first GAP cycle
- err  out  1  1-cycle pulse on rejected start

Behaviour:
- Reset (asynchronous, resetn=0): state=IDLE; pkt_valid, data_out, pl_ready, tx_active, done, err all 0. Parity register and index cleared. Buffer contents are don't-care. Reset mid-packet aborts the packet immediately with no parity byte.
- All outputs are driven from flops and update on the same edge as state changes.
- States: IDLE, LOAD, HEADER, PAYLOAD, PARITY, GAP.
- IDLE: start=1 with addr_in==3, len_in==0, or len_in>MAX_LEN → err pulse next cycle, remain in IDLE. Otherwise capture addr/len, set parity=header, idx=0, go to LOAD.
- LOAD: pl_ready=1. Each cycle with pl_valid=1 writes buf[idx], sets parity ^= pl_data, and increments idx. Gaps in pl_valid are allowed. The len-th accepted byte causes pl_ready=0 and a move to HEADER. Payload bytes are never accepted outside LOAD.
- HEADER: pkt_valid=1, data_out={len,addr}. This state is entered on the edge after the final load write.
- Transmit advance rule: in HEADER, PAYLOAD and PARITY, a rising edge with busy=0 advances to the next byte. With busy=1, data_out and pkt_valid hold unchanged. busy in other states is ignored.
- PAYLOAD: pkt_valid=1, data_out=buf[idx], with idx reset to 0 on entry. After buf[len-1] advances, go to PARITY.
- PARITY: pkt_valid=0, data_out=parity byte (XOR of header and all payload bytes). On advance go to GAP.
- GAP: pkt_valid=0, data_out=0, done=1 for the first cycle only. Stay GAP_CYCLES cycles, then go to IDLE.
- start outside IDLE is ignored (no err). tx_active=1 in every state except IDLE.
- Parity/XOR is 8-bit with no width growth. idx is 6 bits and never wraps because len ≤ 63.

Optional Feature:
Macro ROUTER_TX_PARITY_CORRUPT_EN.
- Defined: corrupt_parity is sampled on the accepted start. If it was 1, the transmitted parity byte is bitwise inverted (~parity), for driving the router err path.
- Undefined: corrupt_parity is ignored, and parity is always correct. The port remains present.

Test Plan:
- addr=2, len=3, payload A5,3C,0F, busy=0 → data_out 0E,A5,3C,0F with pkt_valid=1, then 98 with pkt_valid=0, then done pulse, tx_active=0 after GAP.
- Same packet, busy=1 for 3 cycles while data_out=3C → 3C and pkt_valid=1 held for exactly 4 cycles, then 0F; parity still 98.
- LOAD with pl_valid pattern 1,0,0,1,0,1 (A5,3C,0F) → identical wire output to the first test; pl_ready drops after the 3rd accepted byte.
- start with addr=3, then with len=0 → err pulse each time, pkt_valid never high, tx_active stays 0.
- resetn=0 asynchronously during PAYLOAD (after A5) → pkt_valid/data_out 0 immediately; new start afterwards sends a clean packet.
- Macro defined, corrupt_parity=1 on the first-test packet → parity byte 67; macro undefined → 98.
